// File: rtl/output_link_tx.sv
// Link transmitter: buffers crossbar flits in a small FIFO and sends them under per-VC on/off flow control.
// Per-VC packet FSMs flag protocol errors. Optional stall counter enabled by TX_STALL_CNT_EN.
package noc_pkg;
  localparam int unsigned VC_NUM = 4;
  localparam int unsigned VC_W   = $clog2(VC_NUM);
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t       flit_label;
    logic [VC_W-1:0]   vc_id;
    logic [DATA_W-1:0] data;
  } flit_t;
endpackage

module output_link_tx
  import noc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  flit_t             xb_flit_i,
  input  logic              xb_valid_i,
  output logic              xb_ready_o,
  input  logic [VC_NUM-1:0] on_off_i,
  output flit_t             data_o,
  output logic              valid_flit_o,
  output logic [VC_NUM-1:0] vc_active_o,
  output logic [VC_NUM-1:0] error_o
`ifdef TX_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } vc_state_e;

  flit_t             mem_q [FIFO_DEPTH];
  flit_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  vc_state_e         state_q [VC_NUM];
  vc_state_e         state_d [VC_NUM];
  logic [VC_NUM-1:0] error_q, error_d;
  flit_t             data_q, data_d;
  logic              valid_q, valid_d;

  flit_t head;
  logic  push;
  logic  pop;
  logic  empty;

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign empty      = (cnt_q == '0);
  assign xb_ready_o = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign push       = xb_valid_i && xb_ready_o;
  assign pop        = !empty && on_off_i[head.vc_id];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    if (push) begin
      mem_d[wr_ptr_q] = xb_flit_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      data_d   = head;
      valid_d  = 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Per-VC packet tracking; only the popped flit's VC advances.
  always_comb begin
    state_d = state_q;
    error_d = error_q;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (pop && (head.vc_id == VC_W'(v))) begin
        case (state_q[v])
          IDLE: begin
            case (head.flit_label)
              HEAD:     state_d[v] = ACTIVE;
              HEADTAIL: state_d[v] = IDLE;
              default:  error_d[v] = 1'b1;
            endcase
          end
          default: begin
            case (head.flit_label)
              TAIL:    state_d[v] = IDLE;
              BODY:    state_d[v] = ACTIVE;
              default: error_d[v] = 1'b1;
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      for (int unsigned v = 0; v < VC_NUM; v++) state_q[v] <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      error_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    vc_active_o = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) vc_active_o[v] = (state_q[v] == ACTIVE);
  end

  assign data_o       = data_q;
  assign valid_flit_o = valid_q;
  assign error_o      = error_q;

`ifdef TX_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles with a buffered head held off by flow control.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!empty && !on_off_i[head.vc_id] && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_output_link_tx.sv
// Scoreboard bench for output_link_tx: accepted flits are queued and matched against the link output.
module tb_output_link_tx;
  import noc_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  flit_t             xb_flit_i = '0;
  logic              xb_valid_i = 1'b0;
  logic              xb_ready_o;
  logic [VC_NUM-1:0] on_off_i = '1;
  flit_t             data_o;
  logic              valid_flit_o;
  logic [VC_NUM-1:0] vc_active_o;
  logic [VC_NUM-1:0] error_o;
`ifdef TX_STALL_CNT_EN
  logic [15:0]       stall_cnt_o;
`endif

  output_link_tx #(.FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .xb_flit_i    (xb_flit_i),
    .xb_valid_i   (xb_valid_i),
    .xb_ready_o   (xb_ready_o),
    .on_off_i     (on_off_i),
    .data_o       (data_o),
    .valid_flit_o (valid_flit_o),
    .vc_active_o  (vc_active_o),
    .error_o      (error_o)
`ifdef TX_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned       n_tests = 0;
  int unsigned       n_fail  = 0;
  int unsigned       cyc     = 0;
  int unsigned       run_len = 0;
  int unsigned       run_max = 0;
  flit_t             sb[$];
  flit_t             mon_exp;
  logic [VC_NUM-1:0] m_active = '0;
  logic [VC_NUM-1:0] m_err    = '0;
  bit                accepted;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic flit_t mk(input flit_label_t l, input int unsigned vc, input logic [31:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = VC_W'(vc);
    f.data       = d;
    return f;
  endfunction

  // Reference packet protocol, applied to each flit as it leaves.
  task automatic model_step(input flit_t f);
    int unsigned v;
    v = 32'(f.vc_id);
    case (f.flit_label)
      HEAD:     if (m_active[v]) m_err[v] = 1'b1; else m_active[v] = 1'b1;
      BODY:     if (!m_active[v]) m_err[v] = 1'b1;
      TAIL:     if (!m_active[v]) m_err[v] = 1'b1; else m_active[v] = 1'b0;
      default:  if (m_active[v]) m_err[v] = 1'b1;
    endcase
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (valid_flit_o) begin
        run_len++;
        if (run_len > run_max) run_max = run_len;
        if (sb.size() == 0) begin
          check("unexpected_flit", 64'(valid_flit_o), 0);
        end else begin
          mon_exp = sb.pop_front();
          check("flit", 64'(data_o), 64'(mon_exp));
          model_step(mon_exp);
        end
      end else begin
        run_len = 0;
      end
      check("vc_active", 64'(vc_active_o), 64'(m_active));
      check("error", 64'(error_o), 64'(m_err));
    end
  end

  task automatic drive(input logic v, input flit_t f);
    @(negedge clk);
    xb_valid_i = v;
    xb_flit_i  = f;
    #1;
    accepted = v && xb_ready_o;
    if (accepted) sb.push_back(f);
  endtask

  task automatic send(input flit_t f, output int unsigned tries);
    tries = 0;
    do begin
      drive(1'b1, f);
      tries++;
    end while (!accepted && tries < 200);
    if (!accepted) check("send_timeout", 64'(accepted), 1);
    @(posedge clk);
    #1 xb_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  64'(xb_ready_o), 1);
    check({tag, "_valid"},  64'(valid_flit_o), 0);
    check({tag, "_data"},   64'(data_o), 0);
    check({tag, "_active"}, 64'(vc_active_o), 0);
    check({tag, "_error"},  64'(error_o), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned tries;
    int unsigned t0;
    flit_t       f;

    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    #2 rst = 1'b1;

    // Single HEADTAIL on vc 1 with one-cycle pop latency
    send(mk(HEADTAIL, 1, 32'h1111_0001), tries);
    t0 = cyc;
    for (int i = 0; i < 20 && !valid_flit_o; i++) @(negedge clk);
    check("ht_latency", 64'(cyc - t0), 1);
    check("ht_active", 64'(vc_active_o), 0);
    drain();

    // Back-to-back packet on vc 0
    run_max = 0;
    send(mk(HEAD, 0, 32'h2222_0001), tries);
    send(mk(BODY, 0, 32'h2222_0002), tries);
    send(mk(TAIL, 0, 32'h2222_0003), tries);
    drain();
    check("pkt_run", 64'(run_max), 3);
    check("pkt_active_end", 64'(vc_active_o[0]), 0);

    // Backpressure on vc 2 with a two-entry FIFO
    on_off_i = 4'b1011;
    send(mk(HEAD, 2, 32'h3333_0001), tries);
    send(mk(BODY, 2, 32'h3333_0002), tries);
    f = mk(TAIL, 2, 32'h3333_0003);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, f);
      check("bp_ready", 64'(xb_ready_o), 0);
      check("bp_valid", 64'(valid_flit_o), 0);
    end
    on_off_i = 4'b1111;
    send(f, tries);
    drain();
    check("bp_active_end", 64'(vc_active_o[2]), 0);

    // Protocol error on vc 3 stays sticky
    send(mk(BODY, 3, 32'h4444_0001), tries);
    drain();
    check("err3_set", 64'(error_o[3]), 1);
    send(mk(HEADTAIL, 3, 32'h4444_0002), tries);
    drain();
    check("err3_sticky", 64'(error_o[3]), 1);
    check("err_others", 64'(error_o[2:0]), 0);

    // Reset mid-packet with a full FIFO
    send(mk(HEAD, 0, 32'h5555_0001), tries);
    drain();
    check("mid_active", 64'(vc_active_o[0]), 1);
    on_off_i = 4'b1110;
    send(mk(BODY, 0, 32'h5555_0002), tries);
    send(mk(BODY, 0, 32'h5555_0003), tries);
    drive(1'b0, '0);
    check("full_ready", 64'(xb_ready_o), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    m_active = '0;
    m_err    = '0;
    on_off_i = 4'b1111;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst_hold");
    f = mk(HEADTAIL, 2, 32'h6666_0001);
    #2;
    xb_flit_i  = f;
    xb_valid_i = 1'b1;
    rst        = 1'b1;
    #1;
    check("first_push_ready", 64'(xb_ready_o), 1);
    sb.push_back(f);
    @(posedge clk);
    #1 xb_valid_i = 1'b0;
    drain();
    check("post_rst_valid", 64'(valid_flit_o), 0);

`ifdef TX_STALL_CNT_EN
    // Stall counter counts blocked-head cycles and saturates
    @(negedge clk);
    #2 rst = 1'b0;
    sb.delete();
    m_active = '0;
    m_err    = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    on_off_i = 4'b1101;
    send(mk(HEADTAIL, 1, 32'h7777_0001), tries);
    repeat (11) @(negedge clk);
    check("stall_10", 64'(stall_cnt_o), 10);
    repeat (70000) @(negedge clk);
    check("stall_sat", 64'(stall_cnt_o), 64'hFFFF);
    on_off_i = 4'b1111;
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
